mux_scan_ctrl: RTL and testbench

// - Upstream sequencer for the 16:1 single-bit selector stage: accepts a 16-bit word (valid/ready),

---
 rtl/mux_scan_pkg.sv | 17 +
 rtl/mux_scan_ctrl_if.sv | 27 ++
 rtl/mux_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_mux_scan_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the 16:1 selector scan controller.
package mux_scan_pkg;
    localparam int N_SEL = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_OUT    = 2'd2,
        ST_PAR    = 2'd3
    } state_e;

    function automatic logic [SEL_W-1:0] end_sel(input bit high);
        return high ? SEL_W'(N_SEL - 1) : '0;
    endfunction
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Word input, selector drive/return and serial bit output of the scan controller.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic [N_SEL-1:0] word_i;
    logic             word_valid;
    logic             word_ready;
    logic [N_SEL-1:0] word_o;
    logic [SEL_W-1:0] sel_o;
    logic             mux_i;
    logic             bit_o;
    logic             bit_valid;
    logic             bit_ready;
    logic             bit_last;
    logic             busy;
    logic             mismatch_o;

    modport slave (
        input  word_i, word_valid, mux_i, bit_ready,
        output word_ready, word_o, sel_o, bit_o, bit_valid, bit_last, busy, mismatch_o
    );

    modport master (
        output word_i, word_valid, mux_i, bit_ready,
        input  word_ready, word_o, sel_o, bit_o, bit_valid, bit_last, busy, mismatch_o
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Steps a 16:1 selector through all codes, samples its return bit and streams it out serially.
// Optional trailing even-parity bit when MUX_SCAN_PARITY_EN is defined.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter bit DESCEND    = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.slave bus
);

`ifdef MUX_SCAN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam logic [SEL_W-1:0] SEL_FIRST = end_sel(DESCEND);
    localparam logic [SEL_W-1:0] SEL_LAST  = end_sel(!DESCEND);
    // Terminal count gives SETTLE_CYC+1 cycles of stable selector inputs before sampling.
    localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(SETTLE_CYC);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [N_SEL-1:0] word_q;
    logic [SEL_W-1:0] sel_q;
    logic             bit_q;
    logic             bvld_q;
    logic             last_q;
    logic             mm_q;
    logic             sel_final;
`ifdef MUX_SCAN_PARITY_EN
    logic             par;
`endif

    assign sel_final = (sel_q == SEL_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            word_q <= '0;
            sel_q  <= '0;
            bit_q  <= 1'b0;
            bvld_q <= 1'b0;
            last_q <= 1'b0;
            mm_q   <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
            par    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.word_valid) begin
                        word_q <= bus.word_i;
                        sel_q  <= SEL_FIRST;
                        mm_q   <= 1'b0;
                        cnt    <= '0;
`ifdef MUX_SCAN_PARITY_EN
                        par    <= 1'b0;
`endif
                        state  <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CNT_END) begin
                        bit_q  <= bus.mux_i;
                        bvld_q <= 1'b1;
                        last_q <= sel_final && !PAR_EN;
                        mm_q   <= mm_q | (bus.mux_i != word_q[sel_q]);
`ifdef MUX_SCAN_PARITY_EN
                        par    <= par ^ bus.mux_i;
`endif
                        state  <= ST_OUT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.bit_ready) begin
                        bvld_q <= 1'b0;
                        last_q <= 1'b0;
                        if (!sel_final) begin
                            sel_q <= DESCEND ? sel_q - SEL_W'(1) : sel_q + SEL_W'(1);
                            cnt   <= '0;
                            state <= ST_SETTLE;
                        end else begin
`ifdef MUX_SCAN_PARITY_EN
                            bit_q  <= par;
                            bvld_q <= 1'b1;
                            last_q <= 1'b1;
                            state  <= ST_PAR;
`else
                            state  <= ST_IDLE;
`endif
                        end
                    end
                end
                ST_PAR: begin
`ifdef MUX_SCAN_PARITY_EN
                    if (bus.bit_ready) begin
                        bvld_q <= 1'b0;
                        last_q <= 1'b0;
                        state  <= ST_IDLE;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is masked while reset is held so every output reads zero during reset.
    assign bus.word_ready = (state == ST_IDLE) && !rst;
    assign bus.busy       = (state != ST_IDLE);
    assign bus.word_o     = word_q;
    assign bus.sel_o      = sel_q;
    assign bus.bit_o      = bit_q;
    assign bus.bit_valid  = bvld_q;
    assign bus.bit_last   = last_q;
    assign bus.mismatch_o = mm_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized self-checking bench: ascending/SETTLE_CYC=1 and descending/SETTLE_CYC=3 instances.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_PARITY_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] word_i;
    logic        wv;
    logic        bit_ready;
    logic        inj_g;
    int          cur;
    int          cyc_cnt = 0;
    int          n_chk = 0;
    int          n_err = 0;

    logic [15:0] o_word;
    logic [3:0]  o_sel;
    logic        o_ready, o_bit, o_bvld, o_last, o_busy, o_mm;

    mux_scan_ctrl_if ia ();
    mux_scan_ctrl_if ib ();

    mux_scan_ctrl #(.SETTLE_CYC(1), .DESCEND(1'b0)) u_asc (.clk(clk), .rst(rst), .bus(ia.slave));
    mux_scan_ctrl #(.SETTLE_CYC(3), .DESCEND(1'b1)) u_dsc (.clk(clk), .rst(rst), .bus(ib.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Selector model; inj_g flips the returned bit at code 7 on the ascending instance.
    assign ia.mux_i      = ia.word_o[ia.sel_o] ^ (inj_g && ia.sel_o == 4'd7);
    assign ib.mux_i      = ib.word_o[ib.sel_o];
    assign ia.word_i     = word_i;
    assign ib.word_i     = word_i;
    assign ia.word_valid = wv && (cur == 0);
    assign ib.word_valid = wv && (cur == 1);
    assign ia.bit_ready  = bit_ready;
    assign ib.bit_ready  = bit_ready;

    always_comb begin
        o_word  = cur == 0 ? ia.word_o     : ib.word_o;
        o_sel   = cur == 0 ? ia.sel_o      : ib.sel_o;
        o_ready = cur == 0 ? ia.word_ready : ib.word_ready;
        o_bit   = cur == 0 ? ia.bit_o      : ib.bit_o;
        o_bvld  = cur == 0 ? ia.bit_valid  : ib.bit_valid;
        o_last  = cur == 0 ? ia.bit_last   : ib.bit_last;
        o_busy  = cur == 0 ? ia.busy       : ib.busy;
        o_mm    = cur == 0 ? ia.mismatch_o : ib.mismatch_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One word through the current instance; expectations come from the word and scan order alone.
    task automatic run_word(input logic [15:0] w, input int rdy_pct, input bit inj,
                            input int stall_bit, input bit hold_v);
        int          settle = (cur == 1) ? 3 : 1;
        bit          desc   = (cur == 1);
        int          acc, nb, first, stall, h16, s;
        logic [16:0] exp_bits;
        logic        p;
        bit          seen7;
        nb = 0; first = -1; stall = 0; h16 = -1; p = 1'b0; exp_bits = '0;
        for (int k = 0; k < 16; k++) begin
            s           = desc ? 15 - k : k;
            exp_bits[k] = w[s] ^ (inj && s == 7);
            p           = p ^ exp_bits[k];
        end
`ifdef MUX_SCAN_PARITY_EN
        exp_bits[16] = p;
`endif
        inj_g = inj;
        @(negedge clk);
        word_i = w; wv = 1'b1; bit_ready = 1'b0;
        chk("idle_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc_cnt;
        if (!hold_v) wv = 1'b0;
        chk("acc_word", 32'(o_word), 32'(w));
        chk("acc_mm_clr", 32'(o_mm), 32'd0);
        chk("acc_sel", 32'(o_sel), desc ? 32'd15 : 32'd0);
        for (int c = 0; c < 600 && nb < NB; c++) begin
            @(negedge clk);
            if (stall_bit == nb && o_bvld && stall < 5) begin
                bit_ready = 1'b0;
                stall++;
            end else begin
                bit_ready = ($urandom_range(99) < rdy_pct);
            end
            if (hold_v) chk("busy_not_ready", 32'(o_ready), 32'd0);
            if (o_bvld) begin
                if (first < 0) begin
                    first = cyc_cnt;
                    chk("first_lat", 32'(first - acc), 32'(settle + 1));
                end
                chk("bit", 32'(o_bit), 32'(exp_bits[nb]));
                chk("last", 32'(o_last), 32'(nb == NB - 1));
                chk("word_hold", 32'(o_word), 32'(w));
                if (nb < 16) begin
                    seen7 = desc ? (nb >= 8) : (nb >= 7);
                    chk("sel", 32'(o_sel), desc ? 32'(15 - nb) : 32'(nb));
                    chk("mm", 32'(o_mm), 32'(inj && seen7));
                end
                if (bit_ready) begin
                    if (nb == 15) h16 = cyc_cnt + 1;
                    nb++;
                end
            end else begin
                chk("last_unqual", 32'(o_last), 32'd0);
            end
        end
        chk("bit_count", 32'(nb), 32'(NB));
        if (rdy_pct == 100 && stall_bit < 0)
            chk("acc_to_last", 32'(h16 - acc), 32'(16 * (settle + 2)));
        @(negedge clk);
        chk("end_busy", 32'(o_busy), 32'd0);
        chk("end_ready", 32'(o_ready), 32'd1);
        chk("end_vld", 32'(o_bvld), 32'd0);
        chk("mm_sticky", 32'(o_mm), 32'(inj));
        wv = 1'b0; bit_ready = 1'b0; inj_g = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; wv = 1'b0; bit_ready = 1'b0; word_i = '0; cur = 0; inj_g = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a", 32'({o_word, o_sel, o_bit, o_bvld, o_last, o_busy, o_mm, o_ready}), 32'd0);
        chk("rst_b", 32'({ib.word_o, ib.sel_o, ib.bit_o, ib.bit_valid, ib.bit_last,
                          ib.busy, ib.mismatch_o, ib.word_ready}), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rel_ready", 32'(o_ready), 32'd1);

        run_word(16'hA5C3, 100, 1'b0, -1, 1'b0);
        run_word(16'h3C5A, 100, 1'b0, 3, 1'b0);
        run_word(16'($urandom), 100, 1'b1, -1, 1'b0);
        run_word(16'($urandom), 100, 1'b0, -1, 1'b0);
        run_word(16'h0007, 100, 1'b0, -1, 1'b0);
        run_word(16'h0003, 100, 1'b0, -1, 1'b0);
        for (int i = 0; i < 6; i++)
            run_word(16'($urandom), 60, 1'($urandom_range(1)), -1, 1'b0);

        // Reset in the middle of a word.
        @(negedge clk);
        word_i = 16'hFFFF; wv = 1'b1;
        @(posedge clk);
        #1 wv = 1'b0; bit_ready = 1'b1;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid", 32'({o_word, o_sel, o_bit, o_bvld, o_last, o_busy, o_mm, o_ready}), 32'd0);
        end
        rst = 1'b0; bit_ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", 32'(o_ready), 32'd1);
        chk("rst_mid_last", 32'(o_last), 32'd0);
        run_word(16'($urandom), 100, 1'b0, -1, 1'b0);

        cur = 1;
        run_word(16'h8001, 100, 1'b0, -1, 1'b1);
        for (int i = 0; i < 4; i++)
            run_word(16'($urandom), 70, 1'b0, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
